life_board_pingpong_mem: RTL and testbench
==========================================

Name: life_board_pingpong_mem

Overview:
- Parametrised successor to the single-port board RAM.
- Holds two board banks: "current" (generation N, read-only to the engine) and "next" (generation N+1, write-only to the engine).
- The generation controller swaps the banks on a handshake. A built-in clear sequencer zeroes the next bank.
- Sits between the life-rule engine and the VGA/board scanner; one board row per memory word.

Parameters:
- WIDTH, 128, bits per row (cells per row).
- DEPTH, 1024, rows per bank; power of two, at least 2.
- AW, 10, address width; must equal log2(DEPTH).

Ports:
- clka  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  read request on the current bank.
- rd_addr  in  AW  read row address.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data holds valid data this cycle.
- wr_en  in  1  write request on the next bank.
- wr_addr  in  AW  write row address.
- wr_data  in  WIDTH  write data.
- swap_req  in  1  level request to exchange the current and next banks.
- swap_ack  out  1  one-cycle pulse when the swap takes effect.
- clr_req  in  1  request to zero every row of the next bank.
- busy  out  1  high while a clear sequence is running.
- cur_bank  out  1  index of the bank currently used as "current".

Behaviour:
- Storage: two inferred WIDTH x DEPTH arrays, bank0 and bank1. Contents are not affected by rst.
- Reset values: rd_data=0, rd_valid=0, swap_ack=0, busy=0, cur_bank=0, state=IDLE, clear counter=0.
- Reads:
  - rd_en sampled at edge k; rd_data and rd_valid are updated at edge k+1, so latency is 1.
  - Bank is selected by cur_bank at issue time.
  - rd_valid is low in any cycle with no read outstanding. rd_data holds its last value when rd_valid is low.
- Writes: wr_en at edge k writes wr_data to next bank[wr_addr]. The data is visible to reads only after a swap.
- Banks never conflict: reads always hit current, writes always hit next.
- State machine:
  - IDLE:
    - clr_req=1 -> CLEAR, counter=0, busy=1.
    - Else swap_req=1 -> toggle cur_bank; swap_ack=1 for exactly one cycle; stay IDLE.
    - Else stay IDLE.
  - CLEAR:
    - Each cycle write 0 to next bank[counter], then counter+1.
    - After writing row DEPTH-1 -> IDLE, busy=0 on the following cycle.
    - A full clear takes DEPTH cycles.
- Priority: clr_req beats swap_req in the same cycle. swap_req is not honoured while busy. It is a level signal, so a held request is serviced in the first IDLE cycle after the clear.
- swap_req held high after swap_ack: one swap per two cycles (ack cycle, then re-sample). The controller must drop swap_req on swap_ack.
- Read issued in the swap cycle returns old-bank data; the next read uses the new bank.
- wr_en during CLEAR is ignored (dropped, not queued). rd_en during CLEAR is served normally.
- clr_req during CLEAR is ignored.
- Counter wraps only through the exit to IDLE; no partial-range clear.
- rst mid-CLEAR: immediate return to IDLE with busy=0 and cur_bank=0. Next bank is left partially cleared; the controller must re-issue clr_req.
- Out-of-range addresses are impossible because AW=log2(DEPTH).

Optional Feature:
- Macro: LIFE_MEM_RD_PIPE_EN.
- Defined: one extra output register on rd_data/rd_valid, so read latency is 2. Bank is still selected at issue. Reset clears both stages.
- Undefined: latency 1 as described above.

Test Plan:
- Reset, then write 0xA5 replicated to row 3, swap, then read row 3 -> rd_valid=1 one cycle after rd_en (two with the macro); rd_data=0xA5A5...A5; cur_bank=1.
- After reset, write 0xFF.. to next row 0, then read row 0 without swapping -> rd_data is not 0xFF.. (current bank untouched), confirming bank isolation.
- Write all rows of next with 0x1, then clr_req for 1 cycle -> busy high for exactly DEPTH=1024 cycles; after a swap, reads of rows 0, 511 and 1023 return 0.
- clr_req and swap_req both high in the same cycle -> clear runs first with no swap_ack during busy; swap_ack appears in the first IDLE cycle; cur_bank toggles once.
- Assert rst at clear cycle 500 -> next cycle busy=0 and cur_bank=0; rows 0..499 read 0 after a swap; wr_en issued during the clear left no data.
- rd_en in the same cycle as the swap -> returns old-bank data. rd_en in the next cycle -> returns new-bank data.

Source files
------------

// File: rtl/life_board_pingpong_mem_if.sv
// Engine-side bundle for the ping-pong board memory: read port on the
// current bank, write port on the next bank, swap and clear handshakes.
interface life_board_pingpong_mem_if #(
    parameter int WIDTH = 128,
    parameter int AW    = 10
);
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             swap_req;
    logic             swap_ack;
    logic             clr_req;
    logic             busy;
    logic             cur_bank;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output swap_req, clr_req,
        input  rd_data, rd_valid, swap_ack, busy, cur_bank
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  swap_req, clr_req,
        output rd_data, rd_valid, swap_ack, busy, cur_bank
    );
endinterface

// File: rtl/life_board_pingpong_mem.sv
// Two-bank board memory: reads hit "current", writes hit "next", with swap and clear.
// Define LIFE_MEM_RD_PIPE_EN for an extra read output register (latency 2).
module life_board_pingpong_mem #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                        clka,
    input  logic                        rst,
    life_board_pingpong_mem_if.slave    bus
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic             r_cur_bank;
    logic             r_swap_ack;
    logic [WIDTH-1:0] r_bank0 [DEPTH];
    logic [WIDTH-1:0] r_bank1 [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_do_swap;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_clr_last;

    assign w_clr_last = (r_cnt == AW'(DEPTH - 1));

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cur_bank <= 1'b0;
            r_swap_ack <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_swap_ack <= w_do_swap;
            if (w_do_swap)
                r_cur_bank <= ~r_cur_bank;
            // Counter wraps to zero on the last clear row, exactly at the exit.
            if (r_state == S_CLEAR)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.clr_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_clr_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_do_swap = 1'b0;
        w_we      = 1'b0;
        w_waddr   = bus.wr_addr;
        w_wdata   = bus.wr_data;
        unique case (r_state)
            S_IDLE: begin
                w_we      = bus.wr_en;
                // The ack cycle blocks re-sampling a held request.
                w_do_swap = bus.swap_req && !bus.clr_req && !r_swap_ack;
            end
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clka) begin
        if (w_we && !rst && r_cur_bank)
            r_bank0[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clka) begin
        if (w_we && !rst && !r_cur_bank)
            r_bank1[w_waddr] <= w_wdata;
    end

    assign w_rd_word = r_cur_bank ? r_bank1[bus.rd_addr]
                                  : r_bank0[bus.rd_addr];

    always_ff @(posedge clka) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en)
                r_rd_data <= w_rd_word;
        end
    end

`ifdef LIFE_MEM_RD_PIPE_EN
    logic [WIDTH-1:0] r_rd_data2;
    logic             r_rd_valid2;

    always_ff @(posedge clka) begin
        if (rst) begin
            r_rd_data2  <= '0;
            r_rd_valid2 <= 1'b0;
        end else begin
            r_rd_valid2 <= r_rd_valid;
            if (r_rd_valid)
                r_rd_data2 <= r_rd_data;
        end
    end

    assign bus.rd_data  = r_rd_data2;
    assign bus.rd_valid = r_rd_valid2;
`else
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
`endif

    assign bus.swap_ack = r_swap_ack;
    assign bus.busy     = (r_state == S_CLEAR);
    assign bus.cur_bank = r_cur_bank;

endmodule

// File: tb/tb_life_board_pingpong_mem.sv
// Directed plus random bench for life_board_pingpong_mem against a bank-array model.
// Honours LIFE_MEM_RD_PIPE_EN for the read latency.
module tb_life_board_pingpong_mem;

    localparam int WIDTH = 128;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
`ifdef LIFE_MEM_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    life_board_pingpong_mem_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    life_board_pingpong_mem #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clka(clka),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] m [2][DEPTH];
    int cur;
    int n_chk;
    int n_fail;
    int cyc;

    task automatic step();
        @(posedge clka);
        #1;
        cyc++;
    endtask

    task automatic chk(string tag, logic [WIDTH-1:0] obs, logic [WIDTH-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic do_write(int a, logic [WIDTH-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
        m[1-cur][a] = d;
    endtask

    task automatic do_read(string tag, int a);
        logic [WIDTH-1:0] exp;
        exp         = m[cur][a];
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(a);
        step();
        bus.rd_en   = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            chk({tag, "_early"}, WIDTH'(bus.rd_valid), '0);
            step();
        end
        chk({tag, "_valid"}, WIDTH'(bus.rd_valid), WIDTH'(1));
        chk({tag, "_data"}, bus.rd_data, exp);
    endtask

    task automatic do_swap(string tag);
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        cur = 1 - cur;
        chk({tag, "_ack"}, WIDTH'(bus.swap_ack), WIDTH'(1));
        chk({tag, "_bank"}, WIDTH'(bus.cur_bank), WIDTH'(cur));
        step();
        chk({tag, "_ackdrop"}, WIDTH'(bus.swap_ack), '0);
    endtask

    task automatic do_clear(string tag);
        int n;
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        n = 0;
        while (bus.busy && n < 2 * DEPTH) begin
            n++;
            step();
        end
        chk({tag, "_busylen"}, WIDTH'(n), WIDTH'(DEPTH));
        for (int r = 0; r < DEPTH; r++) m[1-cur][r] = '0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] oldv;
        logic [WIDTH-1:0] newv;
        int c0;
        int n;
        int acks;
        int acks_busy;
        int c_start;

        n_chk = 0; n_fail = 0; cyc = 0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.swap_req = 1'b0; bus.clr_req = 1'b0;

        do_reset();
        do_clear("init1");
        do_swap("init_sw1");
        do_clear("init2");
        do_swap("init_sw2");

        do_reset();
        chk("rst_rd_data", bus.rd_data, '0);
        chk("rst_rd_valid", WIDTH'(bus.rd_valid), '0);
        chk("rst_swap_ack", WIDTH'(bus.swap_ack), '0);
        chk("rst_busy", WIDTH'(bus.busy), '0);
        chk("rst_cur_bank", WIDTH'(bus.cur_bank), '0);

        do_write(3, {(WIDTH/8){8'hA5}});
        do_swap("a5_swap");
        do_read("a5_row3", 3);
        chk("a5_value", bus.rd_data, {(WIDTH/8){8'hA5}});
        step();
        chk("hold_valid_low", WIDTH'(bus.rd_valid), '0);
        chk("hold_data", bus.rd_data, {(WIDTH/8){8'hA5}});

        do_reset();
        do_write(0, '1);
        do_read("iso_row0", 0);
        chk("iso_not_ones", WIDTH'(bus.rd_data === {WIDTH{1'b1}}), '0);

        for (int r = 0; r < DEPTH; r++) do_write(r, WIDTH'(1));
        do_clear("clr_full");
        do_swap("clr_swap");
        do_read("clr_r0", 0);
        do_read("clr_r511", 511);
        do_read("clr_r1023", 1023);

        c_start = cur;
        bus.clr_req  = 1'b1;
        bus.swap_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        chk("pri_busy", WIDTH'(bus.busy), WIDTH'(1));
        n = 0; acks_busy = 0;
        while (bus.busy && n < 2 * DEPTH) begin
            if (bus.swap_ack) acks_busy++;
            n++;
            step();
        end
        chk("pri_busylen", WIDTH'(n), WIDTH'(DEPTH));
        chk("pri_no_ack_busy", WIDTH'(acks_busy), '0);
        acks = 0; n = 0;
        while (acks == 0 && n < 3) begin
            step();
            n++;
            if (bus.swap_ack) begin
                acks++;
                bus.swap_req = 1'b0;
            end
        end
        bus.swap_req = 1'b0;
        chk("pri_ack_delay", WIDTH'(n), WIDTH'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.swap_ack) acks++;
        end
        for (int r = 0; r < DEPTH; r++) m[1-cur][r] = '0;
        cur = 1 - c_start;
        chk("pri_ack_once", WIDTH'(acks), WIDTH'(1));
        chk("pri_bank", WIDTH'(bus.cur_bank), WIDTH'(cur));

        do_reset();
        do_write(499, rnd_word());
        do_write(500, rnd_word());
        do_write(700, rnd_word());
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        c0 = cyc;
        chk("rc_busy", WIDTH'(bus.busy), WIDTH'(1));
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(700);
        bus.wr_data = rnd_word();
        step();
        bus.wr_en = 1'b0;
        do_read("rc_rd_in_clear", 5);
        while (cyc < c0 + 500) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rc_busy_after_rst", WIDTH'(bus.busy), '0);
        chk("rc_bank_after_rst", WIDTH'(bus.cur_bank), '0);
        for (int r = 0; r < 500; r++) m[1][r] = '0;
        cur = 0;
        do_swap("rc_swap");
        do_read("rc_r0", 0);
        do_read("rc_r499", 499);
        do_read("rc_r500", 500);
        do_read("rc_r700", 700);

        d = rnd_word();
        if (d === m[cur][7]) d = ~d;
        do_write(7, d);
        oldv = m[cur][7];
        newv = m[1-cur][7];
        bus.swap_req = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = AW'(7);
        step();
        bus.swap_req = 1'b0;
        cur = 1 - cur;
        chk("sr_ack", WIDTH'(bus.swap_ack), WIDTH'(1));
        if (LAT == 1) chk("sr_old", bus.rd_data, oldv);
        step();
        bus.rd_en = 1'b0;
        if (LAT == 1) chk("sr_new", bus.rd_data, newv);
        else          chk("sr_old", bus.rd_data, oldv);
        if (LAT == 2) begin
            step();
            chk("sr_new", bus.rd_data, newv);
        end
        step();

        for (int it = 0; it < 300; it++) begin
            int op;
            int a;
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 15));
            case (op)
                0, 1: do_write(a, rnd_word());
                2:    do_read("rnd_rd", a);
                default: do_swap("rnd_swap");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
